// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the memory-stage load/store responder.
package data_mem_pkg;

  localparam int DW = 32;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, RD, MERGE, DONE} state_e;

  // Request is rejected if its funct3 is not valid for the direction or the
  // address is not naturally aligned for the access size.
  function automatic logic is_illegal(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic bad_f3;
    logic misal;
    if (we) bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W});
    else    bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    case (funct3)
      F3_W:       misal = (addr_lo != 2'b00);
      F3_H, F3_HU: misal = addr_lo[0];
      default:    misal = 1'b0;
    endcase
    return bad_f3 | misal;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/half lane handling around a word-wide RAM: load extraction with
// sign/zero extension, and store merge of new lanes into the old word.
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [2:0]    funct3_i,
  input  logic [1:0]    addr_lo_i,
  input  logic [DW-1:0] old_word_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] load_data_o,
  output logic [DW-1:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian lane select from the old word
  always_comb begin
    byte_sel = old_word_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? old_word_i[31:16] : old_word_i[15:0];
  end

  // Extract path: selected lane extended to a full word
  always_comb begin
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data_o = {24'h0, byte_sel};
      F3_HU:   load_data_o = {16'h0, half_sel};
      default: load_data_o = old_word_i;
    endcase
  end

  // Merge path: low store bytes overwrite the addressed lane only
  always_comb begin
    merged_o = old_word_i;
    case (funct3_i)
      F3_B: merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_H: begin
        if (addr_lo_i[1]) merged_o[31:16] = wdata_i[15:0];
        else              merged_o[15:0]  = wdata_i[15:0];
      end
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Memory-stage data responder: one request at a time, owns a single-port
// synchronous-read RAM; sub-word stores done as read-modify-write.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_WORDS_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  busy_o
);

  localparam int AW = MEM_WORDS_LOG2;

  state_e                state_q, state_d;
  logic                  accept, req_err, req_sw;
  logic [AW-1:0]         req_idx;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [1:0]            addr_lo_q;
  logic [AW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] ram [2**AW];
  logic [DATA_WIDTH-1:0] ram_rdata_q;
  logic [AW-1:0]         ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_we, ram_re;
  logic [DATA_WIDTH-1:0] load_data, merged;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  unused_addr_hi;

  // Upper address bits are ignored: addresses wrap modulo the RAM size
  assign unused_addr_hi = ^req_addr_i[ADDR_WIDTH-1:AW+2];

  // Request decode
  always_comb begin
    accept  = req_valid_i && req_ready_o;
    req_err = is_illegal(req_we_i, req_funct3_i, req_addr_i[1:0]);
    req_sw  = req_we_i && (req_funct3_i == F3_W);
    req_idx = req_addr_i[AW+1:2];
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = (req_err || req_sw) ? DONE : RD;
      RD:    state_d = we_q ? MERGE : DONE;
      MERGE: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready_o = (state_q == IDLE);
    busy_o      = (state_q != IDLE);
    rsp_valid_o = (state_q == DONE);
  end

  // Capture the accepted request for the later RAM phases
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      addr_lo_q <= 2'b00;
      idx_q     <= '0;
      wdata_q   <= '0;
    end else if (accept) begin
      we_q      <= req_we_i;
      funct3_q  <= req_funct3_i;
      addr_lo_q <= req_addr_i[1:0];
      idx_q     <= req_idx;
      wdata_q   <= req_wdata_i;
    end
  end

  mem_lane_align u_align (
    .funct3_i    (funct3_q),
    .addr_lo_i   (addr_lo_q),
    .old_word_i  (ram_rdata_q),
    .wdata_i     (wdata_q),
    .load_data_o (load_data),
    .merged_o    (merged)
  );

  // Single RAM port: request address while idle, captured address after.
  // Reset gates both enables so a dropped RMW never writes.
  always_comb begin
    ram_addr  = (state_q == IDLE) ? req_idx : idx_q;
    ram_wdata = (state_q == MERGE) ? merged : req_wdata_i;
    ram_we    = !rst_i && ((accept && !req_err && req_sw) || (state_q == MERGE));
    ram_re    = !rst_i && accept && !req_err && !req_sw;
  end

  // Inferred synchronous-read RAM, contents not reset
  always_ff @(posedge clk_i) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata_q   <= ram[ram_addr];
  end

  // Response registers load on entry to DONE and hold otherwise
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && (req_err || req_sw)) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= req_err;
          end
        end
        RD: begin
          if (!we_q) begin
            rsp_rdata_q <= load_data;
            rsp_err_q   <= 1'b0;
          end
        end
        MERGE: begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
